ray_pixel_scheduler: RTL and testbench

- Frame-level sequencer that feeds the ray/block intersection pipeline.
- On a frame start it snapshots the 12 block positions and visibility flags, then issues pixel coordinates in raster order.
- Issue is gated by an in-flight limit and counts returning results. Once the last result is back it signals frame done.
- Block positions stay frozen for the whole frame, so every pixel of a frame is tested against one consistent scene.

---
 rtl/ray_pixel_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_ray_pixel_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ray_pixel_scheduler
// Purpose  : Frame sequencer for the ray/block intersection pipeline. It
//            snapshots the block scene on frame start, then issues pixel
//            coordinates in raster order. Issue is throttled by an in-flight
//            limit. Frame done is signalled once every result has returned.
// Options  : SCHED_PERF_CNT_EN adds the stall_cycles_out and
//            frame_cycles_out performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module ray_pixel_scheduler #(
   parameter int H_PIXELS     = 1024,
   parameter int V_PIXELS     = 768,
   parameter int MAX_INFLIGHT = 192,
   parameter int NUM_BLOCKS   = 12
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         frame_start_in,
   input  logic                         abort_in,
   input  logic [NUM_BLOCKS-1:0][11:0]  block_x_in,
   input  logic [NUM_BLOCKS-1:0][11:0]  block_y_in,
   input  logic [NUM_BLOCKS-1:0][13:0]  block_z_in,
   input  logic [NUM_BLOCKS-1:0]        block_visible_in,
   input  logic                         result_valid_in,
   output logic [10:0]                  x_out,
   output logic [9:0]                   y_out,
   output logic                         pix_valid_out,
   output logic [NUM_BLOCKS-1:0][11:0]  block_x_out,
   output logic [NUM_BLOCKS-1:0][11:0]  block_y_out,
   output logic [NUM_BLOCKS-1:0][13:0]  block_z_out,
   output logic [NUM_BLOCKS-1:0]        block_visible_out,
   output logic                         busy_out,
   output logic                         frame_done_out,
   output logic [7:0]                   inflight_out,
`ifdef SCHED_PERF_CNT_EN
   output logic [31:0]                  stall_cycles_out,
   output logic [31:0]                  frame_cycles_out,
`endif
   output logic                         err_underflow_out
);

   localparam logic [10:0] c_X_LAST   = 11'(H_PIXELS - 1);
   localparam logic [9:0]  c_Y_LAST   = 10'(V_PIXELS - 1);
   localparam logic [7:0]  c_MAX_INFL = 8'(MAX_INFLIGHT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   logic [10:0] r_x;
   logic [9:0]  r_y;
   logic [7:0]  r_inflight;
   logic        r_err_underflow;

   logic        w_accept;
   logic        w_issue;
   logic        w_last_pix;
   logic        w_underflow;
   logic [7:0]  w_inflight_next;

   // Frame acceptance, pixel issue qualification and in-flight next value
   always_comb begin
      w_accept        = (r_state == ST_IDLE) && frame_start_in;
      w_issue         = (r_state == ST_ISSUE) && !abort_in && (r_inflight < c_MAX_INFL);
      w_last_pix      = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
      w_underflow     = result_valid_in && !w_issue && (r_inflight == 8'd0);
      w_inflight_next = r_inflight;
      case ({w_issue, result_valid_in})
         2'b10: begin
            // Issue is already gated below the limit; the hold keeps the
            // counter pinned at the limit should that gating ever change.
            if (r_inflight != c_MAX_INFL) begin
               w_inflight_next = r_inflight + 8'd1;
            end
         end
         2'b01: begin
            // A result with nothing outstanding leaves the counter at zero.
            if (r_inflight != 8'd0) begin
               w_inflight_next = r_inflight - 8'd1;
            end
         end
         default: w_inflight_next = r_inflight;
      endcase
   end

   // In-flight counter and sticky underflow flag
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_inflight      <= 8'd0;
         r_err_underflow <= 1'b0;
      end else begin
         r_inflight <= w_inflight_next;
         if (w_underflow) begin
            r_err_underflow <= 1'b1;
         end
      end
   end

   assign inflight_out      = r_inflight;
   assign err_underflow_out = r_err_underflow;

   // Scene snapshot: frozen for the frame so every pixel sees one scene
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         block_x_out       <= '0;
         block_y_out       <= '0;
         block_z_out       <= '0;
         block_visible_out <= '0;
      end else if (w_accept) begin
         block_x_out       <= block_x_in;
         block_y_out       <= block_y_in;
         block_z_out       <= block_z_in;
         block_visible_out <= block_visible_in;
      end
   end

   // Frame FSM with raster counters and registered pixel/status outputs
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state        <= ST_IDLE;
         r_x            <= 11'd0;
         r_y            <= 10'd0;
         x_out          <= 11'd0;
         y_out          <= 10'd0;
         pix_valid_out  <= 1'b0;
         busy_out       <= 1'b0;
         frame_done_out <= 1'b0;
      end else begin
         pix_valid_out  <= 1'b0;
         frame_done_out <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state  <= ST_ISSUE;
                  r_x      <= 11'd0;
                  r_y      <= 10'd0;
                  busy_out <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (abort_in) begin
                  // Already-issued pixels are still counted back in DRAIN.
                  r_state <= ST_DRAIN;
               end else if (w_issue) begin
                  pix_valid_out <= 1'b1;
                  x_out         <= r_x;
                  y_out         <= r_y;
                  if (w_last_pix) begin
                     r_state <= ST_DRAIN;
                  end else if (r_x == c_X_LAST) begin
                     r_x <= 11'd0;
                     r_y <= r_y + 10'd1;
                  end else begin
                     r_x <= r_x + 11'd1;
                  end
               end
            end
            ST_DRAIN: begin
               // Uses the post-update count so the final return ends the drain.
               if (w_inflight_next == 8'd0) begin
                  r_state        <= ST_DONE;
                  busy_out       <= 1'b0;
                  frame_done_out <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state  <= ST_IDLE;
               busy_out <= 1'b0;
            end
         endcase
      end
   end

`ifdef SCHED_PERF_CNT_EN
   logic [31:0] r_frame_cnt;
   logic        w_stall;
   logic        w_enter_done;

   assign w_stall      = (r_state == ST_ISSUE) && !abort_in && (r_inflight == c_MAX_INFL);
   assign w_enter_done = (r_state == ST_DRAIN) && (w_inflight_next == 8'd0);

   // Stall and frame-length counters, both saturating
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         stall_cycles_out <= 32'd0;
         frame_cycles_out <= 32'd0;
         r_frame_cnt      <= 32'd0;
      end else if (w_accept) begin
         stall_cycles_out <= 32'd0;
         r_frame_cnt      <= 32'd0;
      end else begin
         if (w_stall && (stall_cycles_out != 32'hFFFF_FFFF)) begin
            stall_cycles_out <= stall_cycles_out + 32'd1;
         end
         if (busy_out && (r_frame_cnt != 32'hFFFF_FFFF)) begin
            r_frame_cnt <= r_frame_cnt + 32'd1;
         end
         if (w_enter_done) begin
            frame_cycles_out <= (r_frame_cnt == 32'hFFFF_FFFF) ? r_frame_cnt
                                                               : r_frame_cnt + 32'd1;
         end
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ray_pixel_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ray_pixel_scheduler
// Purpose  : Scoreboard bench for ray_pixel_scheduler. Instance A (4x2,
//            limit 16) covers raster order, snapshot, abort, same-edge
//            update, underflow and reset. Instance B (4x2, limit 3) covers
//            in-flight throttling.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ray_pixel_scheduler;
   localparam int H = 4;
   localparam int V = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_in;

   // Instance A signals
   logic               fs_a, abort_a, rv_a;
   logic [11:0][11:0]  bx_a, by_a;
   logic [11:0][13:0]  bz_a;
   logic [11:0]        bv_a;
   logic [10:0]        x_a;
   logic [9:0]         y_a;
   logic               pix_a, busy_a, done_a, err_a;
   logic [7:0]         infl_a;
   logic [11:0][11:0]  bx_out_a, by_out_a;
   logic [11:0][13:0]  bz_out_a;
   logic [11:0]        bv_out_a;

   // Instance B signals
   logic               fs_b, abort_b, rv_b;
   logic [11:0][11:0]  bx_b, by_b;
   logic [11:0][13:0]  bz_b;
   logic [11:0]        bv_b;
   logic [10:0]        x_b;
   logic [9:0]         y_b;
   logic               pix_b, busy_b, done_b, err_b;
   logic [7:0]         infl_b;
   logic [11:0][11:0]  bx_out_b, by_out_b;
   logic [11:0][13:0]  bz_out_b;
   logic [11:0]        bv_out_b;
`ifdef SCHED_PERF_CNT_EN
   logic [31:0] stall_a, fcyc_a, stall_b, fcyc_b;
`endif

   ray_pixel_scheduler #(.H_PIXELS(H), .V_PIXELS(V), .MAX_INFLIGHT(16), .NUM_BLOCKS(12)) u_dut_a (
      .clk_in(clk), .rst_in(rst_in), .frame_start_in(fs_a), .abort_in(abort_a),
      .block_x_in(bx_a), .block_y_in(by_a), .block_z_in(bz_a), .block_visible_in(bv_a),
      .result_valid_in(rv_a), .x_out(x_a), .y_out(y_a), .pix_valid_out(pix_a),
      .block_x_out(bx_out_a), .block_y_out(by_out_a), .block_z_out(bz_out_a),
      .block_visible_out(bv_out_a), .busy_out(busy_a), .frame_done_out(done_a),
      .inflight_out(infl_a),
`ifdef SCHED_PERF_CNT_EN
      .stall_cycles_out(stall_a), .frame_cycles_out(fcyc_a),
`endif
      .err_underflow_out(err_a));

   ray_pixel_scheduler #(.H_PIXELS(H), .V_PIXELS(V), .MAX_INFLIGHT(3), .NUM_BLOCKS(12)) u_dut_b (
      .clk_in(clk), .rst_in(rst_in), .frame_start_in(fs_b), .abort_in(abort_b),
      .block_x_in(bx_b), .block_y_in(by_b), .block_z_in(bz_b), .block_visible_in(bv_b),
      .result_valid_in(rv_b), .x_out(x_b), .y_out(y_b), .pix_valid_out(pix_b),
      .block_x_out(bx_out_b), .block_y_out(by_out_b), .block_z_out(bz_out_b),
      .block_visible_out(bv_out_b), .busy_out(busy_b), .frame_done_out(done_b),
      .inflight_out(infl_b),
`ifdef SCHED_PERF_CNT_EN
      .stall_cycles_out(stall_b), .frame_cycles_out(fcyc_b),
`endif
      .err_underflow_out(err_b));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard queues of expected {y,x}
   logic [20:0] exp_a[$];
   logic [20:0] exp_b[$];
   int pix_cyc_a[$];
   int cyc        = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;
   int cnt_b      = 0;
   int max_infl_b = 0;

   task automatic push_pixels_a(input int n);
      for (int i = 0; i < n; i++) exp_a.push_back({10'(i / H), 11'(i % H)});
   endtask

   task automatic push_pixels_b(input int n);
      for (int i = 0; i < n; i++) exp_b.push_back({10'(i / H), 11'(i % H)});
   endtask

   // Pipeline return models: a result comes back lat cycles after issue
   int          lat_a    = 5;
   logic        inject_a = 1'b0;
   logic [15:0] hist_a   = '0;
   logic [15:0] hist_b   = '0;

   initial begin
      rv_a = 1'b0;
      forever begin
         @(negedge clk);
         hist_a = {hist_a[14:0], pix_a};
         rv_a   = hist_a[lat_a-1] | inject_a;
      end
   end

   initial begin
      rv_b = 1'b0;
      forever begin
         @(negedge clk);
         hist_b = {hist_b[14:0], pix_b};
         rv_b   = hist_b[9];
      end
   end

   // Monitor A: pop and compare every issued pixel
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (pix_a === 1'b1) begin
            if (exp_a.size() == 0) begin
               check("pix_a_unexpected", 32'(1), 32'(0));
            end else begin
               logic [20:0] e;
               e = exp_a.pop_front();
               check("pix_a_xy", 32'({y_a, x_a}), 32'(e));
               pix_cyc_a.push_back(cyc);
            end
         end
         if (done_a === 1'b1) done_cnt_a++;
      end
   end

   // Monitor B: pop and compare pixels, track peak in-flight
   initial begin
      forever begin
         @(negedge clk);
         if (pix_b === 1'b1) begin
            cnt_b++;
            if (exp_b.size() == 0) begin
               check("pix_b_unexpected", 32'(1), 32'(0));
            end else begin
               logic [20:0] e;
               e = exp_b.pop_front();
               check("pix_b_xy", 32'({y_b, x_b}), 32'(e));
            end
         end
         if (int'(infl_b) > max_infl_b) max_infl_b = int'(infl_b);
         if (done_b === 1'b1) done_cnt_b++;
      end
   end

   task automatic wait_done_a(input string name);
      int k = 0;
      while (done_a !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check({name, "_done_seen"}, 32'(done_a), 32'(1));
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_done_b(input string name);
      int k = 0;
      while (done_b !== 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      check({name, "_done_seen"}, 32'(done_b), 32'(1));
      repeat (3) @(negedge clk);
   endtask

   task automatic frame_end_checks_a(input string name, input int d0);
      check({name, "_done_pulses"}, 32'(done_cnt_a), 32'(d0 + 1));
      check({name, "_busy_after"},  32'(busy_a), 32'(0));
      check({name, "_inflight"},    32'(infl_a), 32'(0));
      check({name, "_sb_empty"},    32'(exp_a.size()), 32'(0));
   endtask

   initial begin
      int d0;
      rst_in = 1'b1;
      fs_a = 1'b0; abort_a = 1'b0; bx_a = '0; by_a = '0; bz_a = '0; bv_a = '0;
      fs_b = 1'b0; abort_b = 1'b0; bx_b = '0; by_b = '0; bz_b = '0; bv_b = '0;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_pix_valid", 32'(pix_a), 32'(0));
      check("rst_busy",      32'(busy_a), 32'(0));
      check("rst_done",      32'(done_a), 32'(0));
      check("rst_xy",        32'({y_a, x_a}), 32'(0));
      check("rst_inflight",  32'(infl_a), 32'(0));
      check("rst_err",       32'(err_a), 32'(0));
      check("rst_snapshot",  32'(|{bx_out_a, by_out_a, bz_out_a, bv_out_a}), 32'(0));
      rst_in = 1'b0;
      repeat (2) @(negedge clk);

      // Full frame, latency 5, live block X changes mid-frame
      bx_a[0] = 12'd5; bv_a = 12'hA5A; bz_a[11] = 14'h2ABC;
      pix_cyc_a.delete();
      push_pixels_a(H * V);
      d0 = done_cnt_a;
      fs_a = 1'b1; @(negedge clk); fs_a = 1'b0;
      check("t1_busy_at_start", 32'(busy_a), 32'(1));
      check("t1_no_pix_yet",    32'(pix_a), 32'(0));
      check("t1_snap_x0",       32'(bx_out_a[0]), 32'(5));
      check("t1_snap_vis",      32'(bv_out_a), 32'(12'hA5A));
      check("t1_snap_z11",      32'(bz_out_a[11]), 32'(14'h2ABC));
      repeat (3) @(negedge clk);
      bx_a[0] = 12'd9;
      wait_done_a("t1");
      frame_end_checks_a("t1", d0);
      check("t1_pix_count", 32'(pix_cyc_a.size()), 32'(8));
      if (pix_cyc_a.size() == 8)
         check("t1_pix_back_to_back", 32'(pix_cyc_a[7] - pix_cyc_a[0]), 32'(7));
      check("t1_snap_x0_frozen", 32'(bx_out_a[0]), 32'(5));

      // Abort after three pixels
      push_pixels_a(3);
      d0 = done_cnt_a;
      fs_a = 1'b1; @(negedge clk); fs_a = 1'b0;
      check("t2_snap_x0_new", 32'(bx_out_a[0]), 32'(9));
      repeat (3) @(negedge clk);
      abort_a = 1'b1; @(negedge clk); abort_a = 1'b0;
      check("t2_no_pix_after_abort", 32'(pix_a), 32'(0));
      check("t2_busy_in_drain",      32'(busy_a), 32'(1));
      check("t2_inflight_drain",     32'(infl_a), 32'(3));
      wait_done_a("t2");
      frame_end_checks_a("t2", d0);

      // Same-edge issue and return keeps in-flight at 2
      repeat (10) @(negedge clk);
      lat_a = 2;
      push_pixels_a(H * V);
      d0 = done_cnt_a;
      fs_a = 1'b1; @(negedge clk); fs_a = 1'b0;
      repeat (3) @(negedge clk);
      check("t3_pix_valid",   32'(pix_a), 32'(1));
      check("t3_inflight_a",  32'(infl_a), 32'(2));
      @(negedge clk);
      check("t3_inflight_b",  32'(infl_a), 32'(2));
      wait_done_a("t3");
      frame_end_checks_a("t3", d0);
      repeat (10) @(negedge clk);
      lat_a = 5;

      // Underflow while idle is sticky
      check("t4_err_before", 32'(err_a), 32'(0));
      inject_a = 1'b1; repeat (2) @(negedge clk);
      inject_a = 1'b0; repeat (2) @(negedge clk);
      check("t4_err_set",      32'(err_a), 32'(1));
      check("t4_inflight_0",   32'(infl_a), 32'(0));
      repeat (5) @(negedge clk);
      check("t4_err_sticky",   32'(err_a), 32'(1));

      // Asynchronous reset mid-issue, then restart
      push_pixels_a(H * V);
      fs_a = 1'b1; @(negedge clk); fs_a = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_in = 1'b1;
      #1;
      check("t5_rst_pix_valid", 32'(pix_a), 32'(0));
      check("t5_rst_busy",      32'(busy_a), 32'(0));
      check("t5_rst_xy",        32'({y_a, x_a}), 32'(0));
      check("t5_rst_inflight",  32'(infl_a), 32'(0));
      check("t5_rst_err",       32'(err_a), 32'(0));
      check("t5_rst_snapshot",  32'(|{bx_out_a, by_out_a, bz_out_a, bv_out_a}), 32'(0));
      exp_a.delete();
      repeat (2) @(negedge clk);
      rst_in = 1'b0;
      repeat (6) @(negedge clk);
      check("t5_late_result_underflow", 32'(err_a), 32'(1));
      check("t5_inflight_after",        32'(infl_a), 32'(0));
      repeat (6) @(negedge clk);
      push_pixels_a(H * V);
      d0 = done_cnt_a;
      fs_a = 1'b1; @(negedge clk); fs_a = 1'b0;
      wait_done_a("t5");
      frame_end_checks_a("t5", d0);
      check("t5_err_still_set", 32'(err_a), 32'(1));

      // In-flight limit 3 with latency 10 on instance B
      push_pixels_b(H * V);
      d0 = done_cnt_b;
      fs_b = 1'b1; @(negedge clk); fs_b = 1'b0;
      repeat (11) @(negedge clk);
      check("t6_pix_before_pause", 32'(cnt_b), 32'(3));
      check("t6_paused",           32'(pix_b), 32'(0));
      @(negedge clk);
      check("t6_resumed",          32'(pix_b), 32'(1));
      wait_done_b("t6");
      check("t6_peak_inflight", 32'(max_infl_b), 32'(3));
      check("t6_pix_count",     32'(cnt_b), 32'(8));
      check("t6_done_pulses",   32'(done_cnt_b), 32'(d0 + 1));
      check("t6_inflight_end",  32'(infl_b), 32'(0));
      check("t6_busy_end",      32'(busy_b), 32'(0));
      check("t6_sb_empty",      32'(exp_b.size()), 32'(0));
`ifdef SCHED_PERF_CNT_EN
      check("t6_stall_nonzero", 32'(stall_b != 32'd0), 32'(1));
      check("t6_fcyc_nonzero",  32'(fcyc_b != 32'd0), 32'(1));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
